// File: rtl/program_loader.sv
// Operator-keyed 16x8 program store for the TD4: nibbles arrive on a debounced-by-edge
// push-button strobe, the CPU reads the same store combinationally like a ROM.
module program_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [3:0] nibble,
  input  logic       strobe,
  input  logic [3:0] cpu_addr,
  output logic [7:0] cpu_data,
  output logic       cpu_hold,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       phase,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync;
  logic                   edge_q;
  logic                   stb;

  logic [7:0] mem [16];

  logic clear_session;
  logic cap_hi;
  logic cap_lo;
  logic abort;

  // stb is registered so it lands exactly SYNC_STAGES+1 edges after strobe is sampled high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      edge_q <= 1'b0;
      stb    <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], strobe};
      edge_q <= sync[SYNC_STAGES-1];
      stb    <= sync[SYNC_STAGES-1] & ~edge_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // load_en low always wins over a simultaneous strobe.
  always_comb begin
    state_next    = state;
    clear_session = 1'b0;
    cap_hi        = 1'b0;
    cap_lo        = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: begin
        if (load_en) begin
          state_next    = HI;
          clear_session = 1'b1;
        end
      end
      HI: begin
        if (!load_en) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (stb) begin
          state_next = LO;
          cap_hi     = 1'b1;
        end
      end
      LO: begin
        if (!load_en) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (stb) begin
          cap_lo     = 1'b1;
          state_next = (wr_addr == 4'd15) ? DONE : HI;
        end
      end
      DONE: begin
        if (!load_en) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr <= 4'd0;
      wr_data <= 8'h00;
      phase   <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (clear_session) begin
        wr_addr <= 4'd0;
        wr_data <= 8'h00;
        phase   <= 1'b0;
        done    <= 1'b0;
      end
      if (abort) begin
        phase <= 1'b0;
      end
      if (cap_hi) begin
        wr_data[7:4] <= nibble;
        phase        <= 1'b1;
      end
      if (cap_lo) begin
        wr_data[3:0] <= nibble;
        mem[wr_addr] <= {wr_data[7:4], nibble};
        phase        <= 1'b0;
        if (wr_addr == 4'd15) begin
          wr_addr <= 4'd0;
          done    <= 1'b1;
        end else begin
          wr_addr <= wr_addr + 4'd1;
        end
      end
    end
  end

  assign cpu_hold = (state != IDLE);
  assign cpu_data = mem[cpu_addr];

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a behavioural model of the loader and strobe path is checked
// against every output on every cycle, plus literal readbacks at the key scenario points.
module tb_program_loader;

  localparam int SYNC = 2;

  logic       clk;
  logic       reset;
  logic       load_en;
  logic [3:0] nibble;
  logic       strobe;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_hold;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       phase;
  logic       done;

  program_loader #(.SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .nibble   (nibble),
    .strobe   (strobe),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_hold (cpu_hold),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .phase    (phase),
    .done     (done)
  );

  // clock/reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: session flag, pointer, byte, phase, done, memory image,
  // and a raw history of sampled strobe levels.
  logic [7:0]      m_mem [16];
  logic            m_active, m_phase, m_done, m_stb, model_valid;
  logic [3:0]      m_addr;
  logic [7:0]      m_data;
  logic [SYNC+1:0] hist;

  initial begin
    model_valid = 1'b0;
    m_active = 1'b0; m_phase = 1'b0; m_done = 1'b0; m_stb = 1'b0;
    m_addr = 4'd0; m_data = 8'h00; hist = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1'b1;
      m_active = 1'b0; m_phase = 1'b0; m_done = 1'b0; m_stb = 1'b0;
      m_addr = 4'd0; m_data = 8'h00; hist = '0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else begin
      if (!m_active) begin
        if (load_en) begin
          m_active = 1'b1; m_addr = 4'd0; m_data = 8'h00; m_phase = 1'b0; m_done = 1'b0;
        end
      end else if (!load_en) begin
        m_active = 1'b0;
        m_phase  = 1'b0;
      end else if (!m_done && m_stb) begin
        if (!m_phase) begin
          m_data[7:4] = nibble;
          m_phase = 1'b1;
        end else begin
          m_data[3:0] = nibble;
          m_mem[m_addr] = m_data;
          m_phase = 1'b0;
          if (m_addr == 4'd15) begin
            m_addr = 4'd0;
            m_done = 1'b1;
          end else begin
            m_addr = m_addr + 4'd1;
          end
        end
      end
      // pulse appears SYNC+1 edges after a rising sample, one cycle wide
      hist  = {hist[SYNC:0], strobe};
      m_stb = hist[SYNC] & ~hist[SYNC+1];
    end
  end

  // scoreboard: every cycle after the first reset edge
  always begin
    @(posedge clk);
    #1;
    if (model_valid) begin
      check("cpu_hold", {7'd0, cpu_hold}, {7'd0, m_active});
      check("wr_addr",  {4'd0, wr_addr},  {4'd0, m_addr});
      check("wr_data",  wr_data,          m_data);
      check("phase",    {7'd0, phase},    {7'd0, m_phase});
      check("done",     {7'd0, done},     {7'd0, m_done});
      check("cpu_data", cpu_data,         m_mem[cpu_addr]);
    end
  end

  logic rand_addr = 1'b1;
  always @(negedge clk) begin
    if (rand_addr) cpu_addr = 4'($urandom_range(0, 15));
  end

  // driver tasks
  task automatic press(input logic [3:0] nib, input int hold);
    @(negedge clk);
    nibble = nib;
    strobe = 1'b1;
    repeat (hold) @(negedge clk);
    strobe = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic press_byte(input logic [7:0] b);
    press(b[7:4], $urandom_range(1, 4));
    press(b[3:0], $urandom_range(1, 4));
  endtask

  // literal readback in the high half of a cycle, away from both edges
  task automatic readback(input string name, input int idx, input logic [7:0] exp);
    @(posedge clk);
    #5;
    cpu_addr = 4'(idx);
    #1;
    check(name, cpu_data, exp);
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; nibble = 4'h0; strobe = 1'b0; cpu_addr = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) readback("reset_mem", i, 8'h00);
    check("reset_wr_addr", {4'd0, wr_addr}, 8'h00);
    check("reset_hold", {7'd0, cpu_hold}, 8'h00);

    // first byte: 3 then A at address 0
    @(negedge clk); load_en = 1'b1;
    press(4'h3, 2);
    check("phase_after_hi", {7'd0, phase}, 8'h01);
    press(4'hA, 1);
    check("phase_after_lo", {7'd0, phase}, 8'h00);
    check("wr_addr_1", {4'd0, wr_addr}, 8'h01);
    readback("mem0_3a", 0, 8'h3A);

    // address 1, then high nibble 7 at address 2 and drop load_en with the low stb
    press_byte(8'h5C);
    press(4'h7, 2);
    @(negedge clk); nibble = 4'h1; strobe = 1'b1;
    repeat (3) @(negedge clk);
    load_en = 1'b0;
    @(negedge clk); strobe = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_addr", {4'd0, wr_addr}, 8'h02);
    check("abort_hold", {7'd0, cpu_hold}, 8'h00);
    readback("abort_mem2", 2, 8'h00);

    // strobes in IDLE are dropped
    press(4'h9, 3);
    press(4'h4, 1);

    // full load 00..0F, one press held for 100 cycles
    @(negedge clk); load_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        press(4'h0, 100);
        press(4'h6, 2);
      end else begin
        press_byte(8'(i));
      end
    end
    check("full_done", {7'd0, done}, 8'h01);
    check("full_wrap", {4'd0, wr_addr}, 8'h00);
    press(4'hF, 2);
    check("done_ignore_phase", {7'd0, phase}, 8'h00);
    for (int i = 0; i < 16; i++) readback("full_mem", i, 8'(i));

    // reset in the middle of a session at address 5
    @(negedge clk); load_en = 1'b0;
    @(negedge clk); load_en = 1'b1;
    for (int i = 0; i < 5; i++) press_byte(8'($urandom_range(0, 255)));
    check("pre_reset_addr", {4'd0, wr_addr}, 8'h05);
    @(negedge clk); reset = 1'b1; load_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    check("rst_done", {7'd0, done}, 8'h00);
    check("rst_hold", {7'd0, cpu_hold}, 8'h00);
    for (int i = 0; i < 16; i++) readback("rst_mem", i, 8'h00);
    press(4'hE, 2);

    // random sessions with random aborts
    for (int s = 0; s < 6; s++) begin
      @(negedge clk); load_en = 1'b1;
      for (int p = 0; p < 40; p++) begin
        press(4'($urandom_range(0, 15)), $urandom_range(1, 4));
        if ($urandom_range(0, 9) == 0) begin
          load_en = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          load_en = 1'b1;
        end
      end
      load_en = 1'b0;
      repeat (3) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
